// File: rtl/product_accumulator_nbit.sv
// ---------------------------------------------------------------------------
// product_accumulator_nbit
//
// Group accumulator placed after the n-bit integer multiplier. Each accepted
// product beat is zero-extended and added into an ACC_WIDTH accumulator. The
// beat flagged with in_last closes the group. The group sum, the beat count
// and a carry-out flag are then held on a valid/ready result port.
//
// Optional build macro: PRODUCT_ACC_SATURATE_EN
//   defined   - on a carry the accumulator clamps to all-ones for the rest
//               of the group.
//   undefined - the sum wraps modulo 2^ACC_WIDTH.
//   out_ovf flags the carry in both builds.
// ---------------------------------------------------------------------------
module product_accumulator_nbit #(
    parameter int WIDTH     = 32,
    parameter int ACC_WIDTH = 48,   // must be >= WIDTH
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_prod,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_sum,
    output logic [CNT_WIDTH-1:0] out_count,
    output logic                 out_ovf
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ACC  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]           state, state_next;
    logic [ACC_WIDTH-1:0] acc, acc_next;
    logic [CNT_WIDTH-1:0] count, count_next;
    logic                 ovf, ovf_next;

    logic [ACC_WIDTH-1:0] prod_ext;
    logic [ACC_WIDTH:0]   sum_ext;
    logic                 carry;
    logic                 beat;

    // The adder is one bit wider than the accumulator; its MSB is the carry.
    assign prod_ext = ACC_WIDTH'(in_prod);
    assign sum_ext  = {1'b0, acc} + {1'b0, prod_ext};
    assign carry    = sum_ext[ACC_WIDTH];

    // Handshake flags depend on state only. in_ready has no path from out_ready.
    assign in_ready  = (state != DONE);
    assign out_valid = (state == DONE);
    assign beat      = in_valid & in_ready;

    // The result port drives the working registers directly. They do not
    // change in DONE because in_ready is low there.
    assign out_sum   = acc;
    assign out_count = count;
    assign out_ovf   = ovf;

    // Next-state and datapath update for one clock.
    always_comb begin
        // NOTE: every signal gets a default before the case. A path that
        // leaves a signal unassigned would otherwise infer a latch.
        state_next = state;
        acc_next   = acc;
        count_next = count;
        ovf_next   = ovf;

        case (state)
            IDLE: begin
                if (beat) begin
                    acc_next   = prod_ext;
                    count_next = CNT_WIDTH'(1);
                    ovf_next   = 1'b0;
                    state_next = in_last ? DONE : ACC;
                end
            end
            ACC: begin
                if (beat) begin
`ifdef PRODUCT_ACC_SATURATE_EN
                    acc_next = (ovf | carry) ? '1 : sum_ext[ACC_WIDTH-1:0];
`else
                    acc_next = sum_ext[ACC_WIDTH-1:0];
`endif
                    count_next = count + CNT_WIDTH'(1);
                    ovf_next   = ovf | carry;
                    state_next = in_last ? DONE : ACC;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and accumulator registers. An asynchronous reset clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment. Every
            // register then samples pre-edge values, so the order of
            // statements does not matter.
            state <= state_next;
            acc   <= acc_next;
            count <= count_next;
            ovf   <= ovf_next;
        end
    end

endmodule
